imem_loader: RTL

Boot-time program loader sitting directly upstream of the instruction memory in `riscv`. It receives a byte stream on a valid/ready link and assembles little-endian 32-bit instruction words. It writes those words into the instruction memory starting at byte address 0, and holds the core in reset until a complete, length-checked (and optionally checksummed) image has been written. It replaces the simulation-only `$readmemb` preload with a synthesizable path, so the same global program can be loaded on hardware.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Loader-side bus bundle: byte stream in, instruction-memory write port out.
// Stream handshake: a byte transfers on a rising edge where in_valid && in_ready; in_data must be stable while in_valid is high.
interface imem_loader_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into imem words and holds the core in reset
// until a full image is written. Define IMEM_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module imem_loader #(
  parameter int PROG_SIZE = 647,
  parameter int AW        = $clog2(PROG_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  imem_loader_if.master      bus,
  output logic               core_rst,
  output logic               done,
  output logic               error,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam logic [15:0] CAP_WORDS = 16'((PROG_SIZE + 1) / 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER_PAYLOAD = S_CHECK;
`else
  localparam state_e S_AFTER_PAYLOAD = S_DONE;
`endif

  state_e        state_q, state_d;
  logic [7:0]    len_lo_q;
  logic [15:0]   len_q;
  logic [15:0]   word_cnt_q;
  logic [1:0]    byte_cnt_q;
  logic [23:0]   word_q;
  logic          imem_we_q;
  logic [AW-1:0] imem_addr_q;
  logic [31:0]   imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  logic        accept;
  logic [15:0] n_words;
  logic        last_byte;
  logic        restart;

  assign accept    = bus.in_valid && bus.in_ready;
  assign n_words   = {bus.in_data, len_lo_q};
  assign last_byte = (byte_cnt_q == 2'd3) && ((word_cnt_q + 16'd1) == len_q);
  assign restart   = load_req && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (load_req) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (n_words > CAP_WORDS)   state_d = S_ERROR;
          else if (n_words == 16'd0) state_d = S_AFTER_PAYLOAD;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) state_d = S_AFTER_PAYLOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (accept) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ERROR keeps in_ready high so a rejected image drains instead of stalling the sender.
  always_comb begin
    bus.in_ready = 1'b0;
    core_rst     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: bus.in_ready = 1'b1;
      S_ERROR: begin
        bus.in_ready = 1'b1;
        error        = 1'b1;
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      if (restart) begin
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q      <= '0;
`endif
      end
      if (accept) begin
        case (state_q)
          S_LEN_LO: len_lo_q <= bus.in_data;
          S_LEN_HI: len_q    <= n_words;
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ bus.in_data;
`endif
            case (byte_cnt_q)
              2'd0: word_q[7:0]   <= bus.in_data;
              2'd1: word_q[15:8]  <= bus.in_data;
              2'd2: word_q[23:16] <= bus.in_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= {word_cnt_q[AW-3:0], 2'b00};
                imem_wdata_q <= {bus.in_data, word_q};
                word_cnt_q   <= word_cnt_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign dbg_state_o    = state_q;

endmodule
